// File: rtl/sap_core_if.sv
// Memory bus between sap_core (master) and its program/data memory (slave).
// Requests are level-held by the master until the slave strobes mem_done.
interface sap_core_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) ();

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;

  modport master (
    output mem_rd,
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_done
  );

  modport slave (
    input  mem_rd,
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_done
  );

endinterface

// File: rtl/sap_core.sv
// Simple-as-possible accumulator CPU: fetch/decode FSM with a single shared
// memory port, 16 opcodes, {C,Z} flags, optional single-step operation.
module sap_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              run_i,
  input  logic              step_mode_i,
  sap_core_if.master        bus,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] acc_o,
  output logic [1:0]        flags_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  output logic              halted_o
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StMemRead,
    StMemWrite,
    StHalt
  } state_e;

  typedef enum logic [3:0] {
    OpNop = 4'h0,
    OpLda = 4'h1,
    OpAdd = 4'h2,
    OpSub = 4'h3,
    OpSta = 4'h4,
    OpLdi = 4'h5,
    OpJmp = 4'h6,
    OpJz  = 4'h7,
    OpAnd = 4'h8,
    OpOr  = 4'h9,
    OpXor = 4'hA,
    OpInc = 4'hB,
    OpDec = 4'hC,
    OpJc  = 4'hD,
    OpOut = 4'hE,
    OpHlt = 4'hF
  } op_e;

  localparam logic [DATA_W:0] AluOne = {{DATA_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              c_q, c_d;
  logic              z_q, z_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  op_e               opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] ldi_val;
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   diff_ext;
  logic [DATA_W:0]   inc_ext;
  logic [DATA_W:0]   dec_ext;
  logic [DATA_W-1:0] alu_acc;
  logic              alu_c;
  state_e            done_state;
  logic              unused_ir;

  assign opcode   = op_e'(ir_q[DATA_W-1 -: 4]);
  assign operand  = ir_q[ADDR_W-1:0];
  assign ldi_val  = {{(DATA_W-ADDR_W){1'b0}}, operand};
  // Bits between opcode and operand are don't-care when DATA_W > ADDR_W+4.
  assign unused_ir = ^ir_q;

  // Extra top bit carries the carry (add/inc) or borrow (sub/dec) out.
  assign sum_ext  = {1'b0, acc_q} + {1'b0, bus.mem_rdata};
  assign diff_ext = {1'b0, acc_q} - {1'b0, bus.mem_rdata};
  assign inc_ext  = {1'b0, acc_q} + AluOne;
  assign dec_ext  = {1'b0, acc_q} - AluOne;

  always_comb begin
    alu_acc = acc_q;
    alu_c   = c_q;
    case (opcode)
      OpLda:   alu_acc = bus.mem_rdata;
      OpAdd:   {alu_c, alu_acc} = sum_ext;
      OpSub:   {alu_c, alu_acc} = diff_ext;
      OpAnd:   alu_acc = acc_q & bus.mem_rdata;
      OpOr:    alu_acc = acc_q | bus.mem_rdata;
      OpXor:   alu_acc = acc_q ^ bus.mem_rdata;
      OpLdi:   alu_acc = ldi_val;
      OpInc:   {alu_c, alu_acc} = inc_ext;
      OpDec:   {alu_c, alu_acc} = dec_ext;
      default: ;
    endcase
  end

  assign done_state = step_mode_i ? StIdle : StFetch;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    acc_d       = acc_q;
    c_d         = c_q;
    z_d         = z_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run_i) state_d = StFetch;
      end
      StFetch: begin
        if (bus.mem_done) begin
          ir_d    = bus.mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = done_state;
        case (opcode)
          OpLda, OpAdd, OpSub, OpAnd, OpOr, OpXor: state_d = StMemRead;
          OpSta: state_d = StMemWrite;
          OpHlt: state_d = StHalt;
          OpJmp: pc_d = operand;
          OpJz:  if (z_q) pc_d = operand;
          OpJc:  if (c_q) pc_d = operand;
          OpOut: begin
            out_data_d  = acc_q;
            out_valid_d = 1'b1;
          end
          OpLdi, OpInc, OpDec: begin
            acc_d = alu_acc;
            c_d   = alu_c;
            z_d   = (alu_acc == '0);
          end
          default: ;
        endcase
      end
      StMemRead: begin
        if (bus.mem_done) begin
          acc_d   = alu_acc;
          c_d     = alu_c;
          z_d     = (alu_acc == '0);
          state_d = done_state;
        end
      end
      StMemWrite: begin
        if (bus.mem_done) state_d = done_state;
      end
      StHalt: ;
      default: state_d = StIdle;
    endcase
  end

  // Memory requests are pure functions of state so they drop the instant
  // reset forces the FSM back to idle.
  always_comb begin
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state_q)
      StFetch: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = pc_q;
      end
      StMemRead: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = operand;
      end
      StMemWrite: begin
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = operand;
        bus.mem_wdata = acc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      ir_q        <= '0;
      acc_q       <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      acc_q       <= acc_d;
      c_q         <= c_d;
      z_q         <= z_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign pc_o        = pc_q;
  assign acc_o       = acc_q;
  assign flags_o     = {c_q, z_q};
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign halted_o    = (state_q == StHalt);

  a_no_rd_wr_overlap: assert property (@(posedge clk_i) !(bus.mem_rd && bus.mem_wr));

endmodule

// File: tb/tb_sap_core.sv
// Directed bench for sap_core: variable-latency memory model, scoreboards for
// OUT strobes and STA writes, plus direct register checks between programs.
`timescale 1ns/1ps
module tb_sap_core;

  localparam int unsigned DataW = 8;
  localparam int unsigned AddrW = 4;

  typedef struct packed {
    logic [3:0]  pc;
    logic [7:0]  acc;
    logic [1:0]  flags;
    logic        has_out;
    logic [7:0]  out_v;
    logic        has_wr;
    logic [11:0] wr_v;
  } step_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run = 1'b0;
  logic             step_mode = 1'b0;
  logic [AddrW-1:0] pc;
  logic [DataW-1:0] acc;
  logic [1:0]       flags;
  logic [DataW-1:0] out_data;
  logic             out_valid;
  logic             halted;

  sap_core_if #(.DATA_W(DataW), .ADDR_W(AddrW)) bus ();

  sap_core #(.DATA_W(DataW), .ADDR_W(AddrW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .run_i       (run),
    .step_mode_i (step_mode),
    .bus         (bus),
    .pc_o        (pc),
    .acc_o       (acc),
    .flags_o     (flags),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .halted_o    (halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem_q [16];
  logic [7:0]  exp_out [$];
  logic [11:0] exp_wr [$];
  int          lat = 0;
  bit          force_done = 1'b0;
  int          wait_cnt = 0;
  bit          pending = 1'b0;
  int          overlaps = 0;
  int          hold_bad = 0;
  int          req_cycles = 0;
  int          accesses = 0;
  int          writes_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Memory slave: answers after `lat` wait cycles; during reset it can be told
  // to strobe mem_done anyway to prove the core ignores it.
  initial begin
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_rd && bus.mem_wr) overlaps++;
      if (!rst_n) begin
        wait_cnt      = 0;
        pending       = 1'b0;
        bus.mem_done  = force_done;
        bus.mem_rdata = 8'hAA;
      end else if (bus.mem_rd || bus.mem_wr) begin
        req_cycles++;
        pending = 1'b1;
        if (wait_cnt >= lat) begin
          bus.mem_done  = 1'b1;
          bus.mem_rdata = mem_q[bus.mem_addr];
          accesses++;
          if (bus.mem_wr) begin
            writes_seen++;
            mem_q[bus.mem_addr] = bus.mem_wdata;
            if (exp_wr.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL sta_unexpected actual=0x%0h required=none",
                       {bus.mem_addr, bus.mem_wdata});
            end else begin
              chk("sta_write", {20'd0, bus.mem_addr, bus.mem_wdata}, {20'd0, exp_wr.pop_front()});
            end
          end
          wait_cnt = 0;
          pending  = 1'b0;
        end else begin
          bus.mem_done = 1'b0;
          wait_cnt++;
        end
      end else begin
        // A request withdrawn before its completion strobe.
        if (pending) hold_bad++;
        bus.mem_done = 1'b0;
        wait_cnt     = 0;
        pending      = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_out.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected actual=0x%0h required=none", out_data);
        end else begin
          chk("out_data", {24'd0, out_data}, {24'd0, exp_out.pop_front()});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem_q[i] = 8'h00;
  endtask

  task automatic clear_stats();
    overlaps    = 0;
    hold_bad    = 0;
    req_cycles  = 0;
    accesses    = 0;
    writes_seen = 0;
  endtask

  task automatic do_reset();
    run   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_halt(input int budget, input string tag, output int cyc);
    cyc = 0;
    while (!halted && cyc < budget) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk(tag, {31'd0, halted}, 32'd1);
  endtask

  task automatic do_step(input step_t s, input string tag);
    if (s.has_out) exp_out.push_back(s.out_v);
    if (s.has_wr) exp_wr.push_back(s.wr_v);
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (8) @(negedge clk);
    chk({tag, "_pc"}, {28'd0, pc}, {28'd0, s.pc});
    chk({tag, "_acc"}, {24'd0, acc}, {24'd0, s.acc});
    chk({tag, "_flags"}, {30'd0, flags}, {30'd0, s.flags});
    chk({tag, "_idle_rd"}, {31'd0, bus.mem_rd}, 32'd0);
  endtask

  // Overflow/borrow program, one instruction per RUN pulse.
  step_t t2_tab [11] = '{
    '{4'h1, 8'hFF, 2'b00, 1'b0, 8'h00, 1'b0, 12'h000},  // LDA F
    '{4'h2, 8'h00, 2'b11, 1'b0, 8'h00, 1'b0, 12'h000},  // ADD E: FF+01
    '{4'h3, 8'h00, 2'b11, 1'b1, 8'h00, 1'b0, 12'h000},  // OUT
    '{4'h4, 8'hFF, 2'b10, 1'b0, 8'h00, 1'b0, 12'h000},  // SUB E: 00-01
    '{4'h5, 8'hFF, 2'b10, 1'b1, 8'hFF, 1'b0, 12'h000},  // OUT
    '{4'h6, 8'hFF, 2'b10, 1'b0, 8'h00, 1'b1, 12'hDFF},  // STA D
    '{4'h7, 8'h00, 2'b11, 1'b0, 8'h00, 1'b0, 12'h000},  // LDI 0
    '{4'h8, 8'hFF, 2'b10, 1'b0, 8'h00, 1'b0, 12'h000},  // DEC
    '{4'h9, 8'h00, 2'b11, 1'b0, 8'h00, 1'b0, 12'h000},  // INC
    '{4'hA, 8'h00, 2'b11, 1'b1, 8'h00, 1'b0, 12'h000},  // OUT
    '{4'hB, 8'h00, 2'b11, 1'b0, 8'h00, 1'b0, 12'h000}   // HLT
  };

  step_t t4_tab [6] = '{
    '{4'hE, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 12'h000},  // JMP E
    '{4'hF, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 12'h000},  // JZ 4, Z=0
    '{4'h0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 12'h000},  // NOP at F wraps
    '{4'h1, 8'h00, 2'b01, 1'b0, 8'h00, 1'b0, 12'h000},  // LDI 0
    '{4'h9, 8'h00, 2'b01, 1'b0, 8'h00, 1'b0, 12'h000},  // JZ 9, Z=1
    '{4'hA, 8'h00, 2'b01, 1'b0, 8'h00, 1'b0, 12'h000}   // JC 3, C=0
  };

  initial begin
    int cyc;
    int n;
    clear_mem();

    // Reset values and idling without RUN.
    do_reset();
    chk("rst_pc", {28'd0, pc}, 32'd0);
    chk("rst_acc", {24'd0, acc}, 32'd0);
    chk("rst_flags", {30'd0, flags}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_mem_req", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
    chk("rst_mem_addr", {28'd0, bus.mem_addr}, 32'd0);
    chk("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
    repeat (5) @(negedge clk);
    chk("idle_no_run_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("idle_no_run_pc", {28'd0, pc}, 32'd0);

    // T1: LDI 1; ADD E; OUT; HLT with zero-wait memory.
    clear_mem();
    mem_q[0] = 8'h51; mem_q[1] = 8'h2E; mem_q[2] = 8'hE0; mem_q[3] = 8'hF0; mem_q[14] = 8'h07;
    mem_q[2] = 8'hE0;
    lat = 0;
    step_mode = 1'b0;
    do_reset();
    exp_out.push_back(8'h08);
    run = 1'b1;
    wait_halt(100, "t1_halted", cyc);
    chk("t1_cycles", cyc, 32'd10);
    repeat (5) @(negedge clk);
    chk("t1_halt_sticky", {31'd0, halted}, 32'd1);
    chk("t1_pc", {28'd0, pc}, 32'd4);
    chk("t1_acc", {24'd0, acc}, 32'h08);
    chk("t1_flags", {30'd0, flags}, 32'd0);
    chk("t1_out_drained", exp_out.size(), 32'd0);
    run = 1'b0;

    // T1b: the exact three-word program {51,2E,FF}; HLT at address 2 leaves PC=3.
    clear_mem();
    mem_q[0] = 8'h51; mem_q[1] = 8'h2E; mem_q[2] = 8'hFF; mem_q[14] = 8'h07;
    do_reset();
    run = 1'b1;
    wait_halt(100, "t1b_halted", cyc);
    chk("t1b_cycles", cyc, 32'd8);
    chk("t1b_pc", {28'd0, pc}, 32'd3);
    chk("t1b_acc", {24'd0, acc}, 32'h08);
    run = 1'b0;

    // T2: stepped overflow/borrow program.
    clear_mem();
    mem_q[0] = 8'h1F; mem_q[1] = 8'h2E; mem_q[2] = 8'hE0; mem_q[3] = 8'h3E;
    mem_q[4] = 8'hE0; mem_q[5] = 8'h4D; mem_q[6] = 8'h50; mem_q[7] = 8'hC0;
    mem_q[8] = 8'hB0; mem_q[9] = 8'hE0; mem_q[10] = 8'hF0;
    mem_q[13] = 8'h00; mem_q[14] = 8'h01; mem_q[15] = 8'hFF;
    step_mode = 1'b1;
    do_reset();
    for (int i = 0; i < 11; i++) do_step(t2_tab[i], $sformatf("t2_s%0d", i));
    chk("t2_halted", {31'd0, halted}, 32'd1);
    chk("t2_mem_d", {24'd0, mem_q[13]}, 32'hFF);
    @(negedge clk); run = 1'b1;
    repeat (3) @(negedge clk); run = 1'b0;
    chk("t2_run_ignored_pc", {28'd0, pc}, 32'hB);
    chk("t2_queues_drained", exp_out.size() + exp_wr.size(), 32'd0);

    // T3: three wait states on every access.
    clear_mem();
    mem_q[0] = 8'h55; mem_q[1] = 8'h4C; mem_q[2] = 8'h2C; mem_q[3] = 8'hE0; mem_q[4] = 8'hF0;
    step_mode = 1'b0;
    lat = 3;
    do_reset();
    clear_stats();
    exp_wr.push_back(12'hC05);
    exp_out.push_back(8'h0A);
    run = 1'b1;
    wait_halt(300, "t3_halted", cyc);
    run = 1'b0;
    chk("t3_cycles", cyc, 32'd34);
    chk("t3_accesses", accesses, 32'd7);
    chk("t3_req_cycles", req_cycles, 32'd28);
    chk("t3_hold_bad", hold_bad, 32'd0);
    chk("t3_overlaps", overlaps, 32'd0);
    chk("t3_writes", writes_seen, 32'd1);
    chk("t3_mem_c", {24'd0, mem_q[12]}, 32'h05);
    chk("t3_pc", {28'd0, pc}, 32'd5);
    chk("t3_acc", {24'd0, acc}, 32'h0A);
    chk("t3_queues_drained", exp_out.size() + exp_wr.size(), 32'd0);

    // T4: PC wrap and conditional jumps, stepped.
    clear_mem();
    mem_q[0] = 8'h6E; mem_q[14] = 8'h74; mem_q[15] = 8'h00;
    step_mode = 1'b1;
    lat = 0;
    do_reset();
    for (int i = 0; i < 3; i++) do_step(t4_tab[i], $sformatf("t4_s%0d", i));
    mem_q[0] = 8'h50; mem_q[1] = 8'h79; mem_q[9] = 8'hD3;
    for (int i = 3; i < 6; i++) do_step(t4_tab[i], $sformatf("t4_s%0d", i));

    // T5: reset while a data read is outstanding.
    clear_mem();
    mem_q[0] = 8'h1F; mem_q[15] = 8'hAA;
    step_mode = 1'b0;
    lat = 6;
    do_reset();
    run = 1'b1;
    n = 0;
    while (!(bus.mem_rd && bus.mem_addr == 4'hF) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_memread", {31'd0, bus.mem_rd && bus.mem_addr == 4'hF}, 32'd1);
    run = 1'b0;
    @(posedge clk);
    #2;
    force_done = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t5_rd_drop", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
    chk("t5_addr", {28'd0, bus.mem_addr}, 32'd0);
    chk("t5_pc", {28'd0, pc}, 32'd0);
    chk("t5_state_out", {22'd0, out_valid, halted, out_data}, 32'd0);
    repeat (3) @(negedge clk);
    chk("t5_acc_no_update", {24'd0, acc}, 32'd0);
    chk("t5_flags", {30'd0, flags}, 32'd0);
    force_done = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_idle_after_rst", {27'd0, bus.mem_rd, pc}, 32'd0);
    chk("t5_no_overlap", overlaps, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
